pwm_bank: RTL and testbench

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank.sv | 133 +++++++++++++
 tb/tb_pwm_bank.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator with a shared edge/center-aligned counter.
// New period, mode and duty values are staged and only applied on a period boundary.
module pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          period,
    input  logic                      center,
    input  logic [CHANNELS*WIDTH-1:0] compare,
    input  logic                      load,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      cycle_start,
    output logic                      pending,
    output logic                      update_done
);

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0]          stg_p_q, stg_p_d;
    logic                      stg_m_q, stg_m_d;
    logic [CHANNELS*WIDTH-1:0] stg_c_q, stg_c_d;
    logic                      pend_q, pend_d;
    logic [WIDTH-1:0]          ps_q, ps_d;
    logic                      ms_q, ms_d;
    logic [CHANNELS*WIDTH-1:0] cs_q, cs_d;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      dir_q, dir_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      cycle_start_q, cycle_start_d;
    logic                      update_done_q, update_done_d;

    logic                      boundary;
    logic                      apply;
    logic [WIDTH-1:0]          eff_p;
    logic                      eff_m;
    logic [CHANNELS*WIDTH-1:0] eff_c;

    always_comb begin
        boundary = enable && (cnt_q == ZERO);
        // A load in the boundary cycle wins the staging slot, so application waits a period.
        apply    = boundary && pend_q && !load;

        stg_p_d = stg_p_q;
        stg_m_d = stg_m_q;
        stg_c_d = stg_c_q;
        pend_d  = pend_q;
        ps_d    = ps_q;
        ms_d    = ms_q;
        cs_d    = cs_q;

        if (load) begin
            stg_p_d = period;
            stg_m_d = center;
            stg_c_d = compare;
            pend_d  = 1'b1;
        end else if (apply) begin
            pend_d = 1'b0;
        end

        if (apply) begin
            ps_d = stg_p_q;
            ms_d = stg_m_q;
            cs_d = stg_c_q;
        end

        // The boundary cycle already belongs to the new period, so it uses the new values.
        eff_p = apply ? stg_p_q : ps_q;
        eff_m = apply ? stg_m_q : ms_q;
        eff_c = apply ? stg_c_q : cs_q;

        cnt_d = ZERO;
        dir_d = 1'b0;
        if (enable && (eff_p != ZERO)) begin
            if (!eff_m) begin
                cnt_d = (cnt_q >= eff_p) ? ZERO : cnt_q + ONE;
            end else if (!dir_q && (cnt_q < eff_p)) begin
                cnt_d = cnt_q + ONE;
            end else begin
                cnt_d = cnt_q - ONE;
                dir_d = (cnt_d != ZERO);
            end
        end

        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable && (cnt_q < eff_c[i*WIDTH +: WIDTH]);
        end

        cycle_start_d = boundary;
        update_done_d = apply;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_p_q       <= ALL_ONES;
            stg_m_q       <= 1'b0;
            stg_c_q       <= '0;
            pend_q        <= 1'b0;
            ps_q          <= ALL_ONES;
            ms_q          <= 1'b0;
            cs_q          <= '0;
            cnt_q         <= ZERO;
            dir_q         <= 1'b0;
            pwm_q         <= '0;
            cycle_start_q <= 1'b0;
            update_done_q <= 1'b0;
        end else begin
            stg_p_q       <= stg_p_d;
            stg_m_q       <= stg_m_d;
            stg_c_q       <= stg_c_d;
            pend_q        <= pend_d;
            ps_q          <= ps_d;
            ms_q          <= ms_d;
            cs_q          <= cs_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            pwm_q         <= pwm_d;
            cycle_start_q <= cycle_start_d;
            update_done_q <= update_done_d;
        end
    end

    assign pwm         = pwm_q;
    assign cycle_start = cycle_start_q;
    assign pending     = pend_q;
    assign update_done = update_done_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: directed scenarios plus random loads, every cycle compared
// against a phase-based model of each period.
module tb_pwm_bank;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk;
    logic            rst;
    logic            enable;
    logic [W-1:0]    period;
    logic            center;
    logic [CH*W-1:0] compare;
    logic            load;
    logic [CH-1:0]   pwm;
    logic            cycle_start;
    logic            pending;
    logic            update_done;

    pwm_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .center(center),
        .compare(compare), .load(load), .pwm(pwm), .cycle_start(cycle_start),
        .pending(pending), .update_done(update_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Model state: position inside the current period plus shadow/staged settings.
    int            m_t;
    int            sh_p, st_p;
    bit            sh_m, st_m;
    int            sh_c[CH];
    int            st_c[CH];
    bit            m_pend;
    logic [CH-1:0] exp_pwm;
    logic          exp_cs;
    logic          exp_ud;

    // Observation bookkeeping.
    int cyc = 0;
    int last_cs_cyc = 0;
    int cs_gap = 0;
    int cs_cnt = 0;
    int ud_cnt = 0;
    int hi[CH];
    bit cs_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int plen(input int p, input bit m);
        if (p == 0) return 1;
        return m ? 2 * p : p + 1;
    endfunction

    function automatic int cnt_at(input int t, input int p, input bit m);
        return (m && t > p) ? 2 * p - t : t;
    endfunction

    task automatic model_reset();
        m_t    = 0;
        sh_p   = (1 << W) - 1;
        st_p   = (1 << W) - 1;
        sh_m   = 1'b0;
        st_m   = 1'b0;
        m_pend = 1'b0;
        for (int i = 0; i < CH; i++) begin
            sh_c[i] = 0;
            st_c[i] = 0;
        end
        exp_pwm = '0;
        exp_cs  = 1'b0;
        exp_ud  = 1'b0;
    endtask

    task automatic model_edge();
        bit bnd;
        bit app;
        int ep;
        bit em;
        int ec[CH];
        bnd = enable && (m_t == 0);
        app = bnd && m_pend && !load;
        ep  = app ? st_p : sh_p;
        em  = app ? st_m : sh_m;
        for (int i = 0; i < CH; i++) ec[i] = app ? st_c[i] : sh_c[i];
        exp_cs = bnd;
        exp_ud = app;
        for (int i = 0; i < CH; i++)
            exp_pwm[i] = enable && (cnt_at(m_t, ep, em) < ec[i]);
        m_t = enable ? (m_t + 1) % plen(ep, em) : 0;
        if (app) begin
            sh_p = st_p;
            sh_m = st_m;
            for (int i = 0; i < CH; i++) sh_c[i] = st_c[i];
        end
        if (load) begin
            st_p = int'(period);
            st_m = center;
            for (int i = 0; i < CH; i++) st_c[i] = int'(compare[i*W +: W]);
            m_pend = 1'b1;
        end else if (app) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("pwm", {28'd0, pwm}, {28'd0, exp_pwm});
        check("cycle_start", {31'd0, cycle_start}, {31'd0, exp_cs});
        check("update_done", {31'd0, update_done}, {31'd0, exp_ud});
        check("pending", {31'd0, pending}, {31'd0, m_pend});
        cs_seen = (cycle_start === 1'b1);
        if (cs_seen) begin
            cs_gap = cyc - last_cs_cyc;
            last_cs_cyc = cyc;
            cs_cnt++;
        end
        if (update_done === 1'b1) ud_cnt++;
        for (int i = 0; i < CH; i++) hi[i] += (pwm[i] === 1'b1) ? 1 : 0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_counts();
        cs_cnt = 0;
        ud_cnt = 0;
        for (int i = 0; i < CH; i++) hi[i] = 0;
    endtask

    task automatic wait_cs(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!cs_seen && n < budget);
        check(tag, {31'd0, cs_seen}, 32'd1);
    endtask

    task automatic do_load(input int p, input bit m, input int c0, input int c1,
                           input int c2, input int c3);
        load    = 1'b1;
        period  = W'(p);
        center  = m;
        compare = {W'(c3), W'(c2), W'(c1), W'(c0)};
        step();
        load    = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        enable  = 1'b0;
        period  = '0;
        center  = 1'b0;
        compare = '0;
        load    = 1'b0;
        model_reset();
        clear_counts();
        #2;
        check("reset_pwm", {28'd0, pwm}, 32'd0);
        check("reset_cycle_start", {31'd0, cycle_start}, 32'd0);
        check("reset_pending", {31'd0, pending}, 32'd0);
        check("reset_update_done", {31'd0, update_done}, 32'd0);
        #10;
        rst = 1'b1;
        run(3);

        // 256-cycle edge-aligned period, four duties.
        do_load(255, 1'b0, 32, 64, 128, 192);
        check("s1_pending", {31'd0, pending}, 32'd1);
        enable = 1'b1;
        wait_cs("s1_first_cs", 600);
        clear_counts();
        run(1024);
        check("s1_hi0", hi[0], 32'd128);
        check("s1_hi1", hi[1], 32'd256);
        check("s1_hi2", hi[2], 32'd512);
        check("s1_hi3", hi[3], 32'd768);
        check("s1_cs_count", cs_cnt, 32'd4);
        check("s1_cs_gap", cs_gap, 32'd256);

        // Center-aligned P=9, C0=5: 18-cycle period, 9 high.
        clear_counts();
        do_load(9, 1'b1, 5, 0, 0, 0);
        wait_cs("s2_apply_cs", 300);
        check("s2_update_done", ud_cnt, 32'd1);
        clear_counts();
        run(36);
        check("s2_hi0", hi[0], 32'd18);
        check("s2_cs_count", cs_cnt, 32'd2);
        check("s2_cs_gap", cs_gap, 32'd18);

        // P=99 then load P=49 mid-period at cnt=40.
        do_load(99, 1'b0, 50, 10, 0, 99);
        wait_cs("s3_apply99", 100);
        run(39);
        clear_counts();
        do_load(49, 1'b0, 25, 10, 0, 60);
        check("s3_pending_after_load", {31'd0, pending}, 32'd1);
        wait_cs("s3_wrap1", 200);
        check("s3_gap100", cs_gap, 32'd100);
        wait_cs("s3_wrap2", 200);
        check("s3_gap50", cs_gap, 32'd50);
        check("s3_update_once", ud_cnt, 32'd1);
        check("s3_pending_clear", {31'd0, pending}, 32'd0);

        // Load in the boundary cycle, then a second load: only the second applies.
        run(49);
        clear_counts();
        do_load(19, 1'b0, 10, 0, 0, 0);
        check("s4_pending_deferred", {31'd0, pending}, 32'd1);
        check("s4_no_update_yet", ud_cnt, 32'd0);
        run(10);
        do_load(29, 1'b0, 7, 3, 0, 30);
        wait_cs("s4_wrap1", 100);
        check("s4_gap50", cs_gap, 32'd50);
        wait_cs("s4_wrap2", 100);
        check("s4_gap30", cs_gap, 32'd30);
        check("s4_update_once", ud_cnt, 32'd1);

        // Duty extremes at P=200, then P=0 with C=1.
        do_load(200, 1'b0, 0, 255, 100, 201);
        wait_cs("s5_apply", 100);
        clear_counts();
        run(402);
        check("s5_c0_const0", hi[0], 32'd0);
        check("s5_c255_const1", hi[1], 32'd402);
        check("s5_c100", hi[2], 32'd200);
        check("s5_c201_const1", hi[3], 32'd402);
        do_load(0, 1'b0, 1, 0, 0, 0);
        wait_cs("s5_apply_p0", 300);
        clear_counts();
        run(20);
        check("s5_p0_hi0", hi[0], 32'd20);
        check("s5_p0_cs_every_cycle", cs_cnt, 32'd20);

        // Asynchronous reset mid-period with a pending update.
        clear_counts();
        do_load(50, 1'b0, 40, 40, 40, 40);
        run(2);
        check("s6_applied", ud_cnt, 32'd1);
        run(10);
        do_load(60, 1'b0, 5, 5, 5, 5);
        run(3);
        #2;
        rst = 1'b0;
        #1;
        check("s6_rst_pwm", {28'd0, pwm}, 32'd0);
        check("s6_rst_cycle_start", {31'd0, cycle_start}, 32'd0);
        check("s6_rst_pending", {31'd0, pending}, 32'd0);
        check("s6_rst_update_done", {31'd0, update_done}, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #4;
        rst = 1'b1;
        wait_cs("s6_first_cs", 10);
        clear_counts();
        wait_cs("s6_wrap", 300);
        check("s6_gap256", cs_gap, 32'd256);
        check("s6_pwm_zero", hi[0] + hi[1] + hi[2] + hi[3], 32'd0);
        check("s6_no_update", ud_cnt, 32'd0);

        // Random loads and enable toggles.
        for (int k = 0; k < 3000; k++) begin
            load = ($urandom_range(0, 24) == 0);
            if (load) begin
                period = W'($urandom_range(0, 20));
                center = 1'($urandom_range(0, 1));
                for (int i = 0; i < CH; i++) compare[i*W +: W] = W'($urandom_range(0, 22));
            end
            if ($urandom_range(0, 299) == 0) enable = !enable;
            step();
        end
        load = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
